serial_compare_controller: RTL and testbench

SERIAL_COMPARE_CONTROLLER -- requirements
Module: serial_compare_controller

---
 rtl/comparator_pkg.sv | 12 +
 rtl/comparator_1_bit.sv | 22 ++
 rtl/serial_compare_controller.sv | 95 +++++++++
 tb/tb_serial_compare_controller.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/comparator_pkg.sv
// Shared types and constants for the bit-serial magnitude comparator.
package comparator_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/comparator_1_bit.sv
// Single-bit unsigned compare; Reset_In forces all outputs low.
module Comparator_1_Bit (
  input  logic Reset_In,
  input  logic A_In,
  input  logic B_In,
  output logic Less_Out,
  output logic Equal_Out,
  output logic Greater_Out
);

  always_comb begin
    Less_Out    = 1'b0;
    Equal_Out   = 1'b0;
    Greater_Out = 1'b0;
    if (!Reset_In) begin
      Less_Out    = ~A_In & B_In;
      Equal_Out   = ~(A_In ^ B_In);
      Greater_Out = A_In & ~B_In;
    end
  end

endmodule

// File: rtl/serial_compare_controller.sv
// MSB-first serial compare of two captured operands with early exit on the
// first differing bit; all outputs are registered.
module serial_compare_controller
  import comparator_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  Clock_In,
  input  logic                  Reset_N_In,
  input  logic                  Start_In,
  input  logic [DATA_WIDTH-1:0] Data_A_In,
  input  logic [DATA_WIDTH-1:0] Data_B_In,
  output logic                  Busy_Out,
  output logic                  Done_Out,
  output logic                  A_Less_Than_B_Out,
  output logic                  A_Equal_To_B_Out,
  output logic                  A_Greater_Than_B_Out
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  state_t                state;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic [DATA_WIDTH-1:0] a_sh, b_sh;
  logic [IDX_W-1:0]      idx;
  logic                  bit_lt, bit_eq, bit_gt;

  // Shift instead of a variable part-select so idx never needs range checks.
  assign a_sh = a_q >> idx;
  assign b_sh = b_q >> idx;

  Comparator_1_Bit u_cmp (
    .Reset_In    (1'b0),
    .A_In        (a_sh[0]),
    .B_In        (b_sh[0]),
    .Less_Out    (bit_lt),
    .Equal_Out   (bit_eq),
    .Greater_Out (bit_gt)
  );

  always_ff @(posedge Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      state                <= IDLE;
      a_q                  <= '0;
      b_q                  <= '0;
      idx                  <= '0;
      Busy_Out             <= 1'b0;
      Done_Out             <= 1'b0;
      A_Less_Than_B_Out    <= 1'b0;
      A_Equal_To_B_Out     <= 1'b0;
      A_Greater_Than_B_Out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Done_Out <= 1'b0;
          if (Start_In) begin
            a_q      <= Data_A_In;
            b_q      <= Data_B_In;
            idx      <= IDX_W'(DATA_WIDTH - 1);
            Busy_Out <= 1'b1;
            state    <= COMPARE;
          end
        end
        COMPARE: begin
          if (!bit_eq) begin
            A_Less_Than_B_Out    <= bit_lt;
            A_Equal_To_B_Out     <= 1'b0;
            A_Greater_Than_B_Out <= bit_gt;
            Done_Out             <= 1'b1;
            state                <= DONE;
          end else if (idx == '0) begin
            A_Less_Than_B_Out    <= 1'b0;
            A_Equal_To_B_Out     <= 1'b1;
            A_Greater_Than_B_Out <= 1'b0;
            Done_Out             <= 1'b1;
            state                <= DONE;
          end else begin
            idx <= idx - IDX_W'(1);
          end
        end
        DONE: begin
          Done_Out <= 1'b0;
          Busy_Out <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          Done_Out <= 1'b0;
          Busy_Out <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_compare_controller.sv
// Directed-vector bench for the serial comparator at widths 8 and 1.
module tb_serial_compare_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, start1;
  logic [7:0] da, db;
  logic [0:0] da1, db1;
  logic       busy, done, lt, eq, gt;
  logic       busy1, done1, lt1, eq1, gt1;

  int n_chk  = 0;
  int n_fail = 0;
  logic [2:0] exp_f8 = 3'b000;  // bench-tracked {lt,eq,gt} of the 8-bit DUT
  logic [2:0] exp_f1 = 3'b000;

  always #5 clk = ~clk;

  serial_compare_controller #(.DATA_WIDTH(8)) u_dut8 (
    .Clock_In(clk), .Reset_N_In(rst_n), .Start_In(start),
    .Data_A_In(da), .Data_B_In(db),
    .Busy_Out(busy), .Done_Out(done),
    .A_Less_Than_B_Out(lt), .A_Equal_To_B_Out(eq), .A_Greater_Than_B_Out(gt)
  );

  serial_compare_controller #(.DATA_WIDTH(1)) u_dut1 (
    .Clock_In(clk), .Reset_N_In(rst_n), .Start_In(start1),
    .Data_A_In(da1), .Data_B_In(db1),
    .Busy_Out(busy1), .Done_Out(done1),
    .A_Less_Than_B_Out(lt1), .A_Equal_To_B_Out(eq1), .A_Greater_Than_B_Out(gt1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Start a compare on the 8-bit DUT, count edges until Done, check result and pulse width.
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] f, input int k_exp);
    int  k;
    bit  seen;
    da = a; db = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    chk({tag, "_hold"}, 64'({lt, eq, gt}), 64'(exp_f8));
    k = 0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      k++;
      if (done) seen = 1;
    end
    chk({tag, "_k"}, 64'(k), 64'(k_exp));
    chk({tag, "_flags"}, 64'({lt, eq, gt}), 64'(f));
    exp_f8 = f;
    @(posedge clk); #1;
    chk({tag, "_done_clr"}, 64'({done, busy}), 64'd0);
    chk({tag, "_flags_hold"}, 64'({lt, eq, gt}), 64'(f));
  endtask

  task automatic run1(input string tag, input logic a, input logic b, input logic [2:0] f);
    start1 = 1'b1; da1 = a; db1 = b;
    @(posedge clk); #1;
    start1 = 1'b0;
    chk({tag, "_busy"}, 64'(busy1), 64'd1);
    chk({tag, "_hold"}, 64'({lt1, eq1, gt1}), 64'(exp_f1));
    @(posedge clk); #1;
    chk({tag, "_done_k1"}, 64'(done1), 64'd1);
    chk({tag, "_flags"}, 64'({lt1, eq1, gt1}), 64'(f));
    exp_f1 = f;
    @(posedge clk); #1;
    chk({tag, "_done_clr"}, 64'({done1, busy1}), 64'd0);
  endtask

  initial begin
    int pulses;
    int k;
    bit seen;
    rst_n = 1'b0; start = 1'b0; start1 = 1'b0;
    da = '0; db = '0; da1 = '0; db1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs8", 64'({busy, done, lt, eq, gt}), 64'd0);
    chk("rst_outs1", 64'({busy1, done1, lt1, eq1, gt1}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_no_result", 64'({busy, done, lt, eq, gt}), 64'd0);

    run8("gt_msb",   8'hA5, 8'h25, 3'b001, 1);
    run8("lt_lsb",   8'h3C, 8'h3D, 3'b100, 8);
    run8("eq_5a",    8'h5A, 8'h5A, 3'b010, 8);
    repeat (3) @(posedge clk);
    #1;
    chk("eq_hold_idle", 64'({lt, eq, gt}), 64'b010);
    run8("lt_msb",   8'h00, 8'hFF, 3'b100, 1);
    run8("gt_b2b",   8'hFF, 8'h00, 3'b001, 1);
    run8("gt_mid",   8'h10, 8'h0F, 3'b001, 4);

    // Second Start with new operands held through COMPARE and DONE must be ignored.
    da = 8'h80; db = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    da = 8'h00; db = 8'hFF;
    pulses = 0;
    @(posedge clk); #1;
    if (done) pulses++;
    chk("ign_flags", 64'({lt, eq, gt}), 64'b001);
    @(posedge clk); #1;
    start = 1'b0;
    if (done) pulses++;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("ign_pulses", 64'(pulses), 64'd1);
    chk("ign_idle", 64'({busy, lt, eq, gt}), 64'b0001);
    exp_f8 = 3'b001;

    // Asynchronous reset in the middle of a 7-edge compare.
    da = 8'h01; db = 8'h02; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy_flags", 64'({busy, done, lt, eq, gt}), 64'd0);
    pulses = 0;
    @(posedge clk); #1;
    if (done) pulses++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("arst_no_done", 64'(pulses), 64'd0);
    chk("arst_idle", 64'({busy, lt, eq, gt}), 64'd0);
    exp_f8 = 3'b000;
    run8("eq_after_rst", 8'h07, 8'h07, 3'b010, 8);

    // Width-1 instance; its reset above also cleared it.
    chk("w1_no_result", 64'({lt1, eq1, gt1}), 64'd0);
    run1("w1_lt", 1'b0, 1'b1, 3'b100);
    run1("w1_eq", 1'b1, 1'b1, 3'b010);
    run1("w1_gt", 1'b1, 1'b0, 3'b001);

    // Bounded wait sanity: a lone start must finish within budget.
    da = 8'hC0; db = 8'hC1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      k++;
      if (done) seen = 1;
    end
    chk("last_k", 64'(k), 64'd8);
    chk("last_flags", 64'({lt, eq, gt}), 64'b100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
